// File: rtl/text_console.sv
// text_console: character-stream terminal writer driving the write port of a text video RAM
module text_console #(
  parameter int COLUMNS = 40,
  parameter int ROWS    = 15,
  parameter int A       = 10,
  parameter int D       = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [A-1:0] mem_addr,
  output logic [D-1:0] mem_wdata,
  output logic         mem_we,
  input  logic [D-1:0] mem_rdata,
  output logic [A-1:0] cursor_addr,
  output logic         busy
);
  localparam int CW = $clog2(COLUMNS);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] COL_MAX  = CW'(COLUMNS - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(ROWS - 1);
  localparam logic [A-1:0]  NCOL     = A'(COLUMNS);
  localparam logic [A-1:0]  LAST_SRC = A'((ROWS - 1) * COLUMNS - 1);
  localparam logic [A-1:0]  LAST_ROW = A'((ROWS - 1) * COLUMNS);
  localparam logic [A-1:0]  LAST     = A'(ROWS * COLUMNS - 1);

  typedef enum logic [2:0] {CLEAR, IDLE, PUT, SCROLL_RD, SCROLL_WR, CLEAR_ROW} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [A-1:0]  idx_q, idx_d;
  logic [7:0]    ch_q, ch_d;
  logic          bs_q, bs_d;
  logic [A-1:0]  cur;

  assign cur = A'(row_q) * NCOL + A'(col_q);

  // reset gates the decoded outputs so nothing is written in the reset cycle
  assign in_ready    = !reset && state_q == IDLE;
  assign busy        = reset || !(state_q inside {IDLE, PUT});
  assign mem_we      = !reset && (state_q inside {PUT, SCROLL_WR, CLEAR_ROW, CLEAR});
  assign mem_addr    = reset ? '0 : state_q == PUT ? cur : state_q == SCROLL_RD ? idx_q + NCOL : idx_q;
  assign mem_wdata   = state_q == PUT ? D'(ch_q) : state_q == SCROLL_WR ? mem_rdata : D'(8'h20);
  assign cursor_addr = reset ? '0 : cur;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    idx_d   = idx_q;
    ch_d    = ch_q;
    bs_d    = bs_q;
    case (state_q)
      IDLE: if (in_valid) begin
        ch_d = in_data;
        bs_d = 1'b0;
        if (in_data >= 8'h20 && in_data <= 8'h7e) state_d = PUT;
        else if (in_data == 8'h0d) col_d = '0;
        else if (in_data == 8'h0a) begin
          col_d = '0;
          if (row_q != ROW_MAX) row_d = row_q + 1'b1;
          else begin
            idx_d   = '0;
            state_d = SCROLL_RD;
          end
        end else if (in_data == 8'h08) begin
          if (col_q != '0) begin
            col_d   = col_q - 1'b1;
            ch_d    = 8'h20;
            bs_d    = 1'b1;
            state_d = PUT;
          end
        end else if (in_data == 8'h0c) begin
          col_d   = '0;
          row_d   = '0;
          idx_d   = '0;
          state_d = CLEAR;
        end
      end
      PUT: begin
        state_d = IDLE;
        if (!bs_q) begin
          if (col_q != COL_MAX) col_d = col_q + 1'b1;
          else begin
            col_d = '0;
            if (row_q != ROW_MAX) row_d = row_q + 1'b1;
            else begin
              idx_d   = '0;
              state_d = SCROLL_RD;
            end
          end
        end
      end
      SCROLL_RD: state_d = SCROLL_WR;
      SCROLL_WR: begin
        idx_d   = idx_q == LAST_SRC ? LAST_ROW : idx_q + 1'b1;
        state_d = idx_q == LAST_SRC ? CLEAR_ROW : SCROLL_RD;
      end
      CLEAR, CLEAR_ROW: begin
        idx_d   = idx_q == LAST ? idx_q : idx_q + 1'b1;
        state_d = idx_q == LAST ? IDLE : state_q;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      col_q   <= '0;
      row_q   <= '0;
      idx_q   <= '0;
      ch_q    <= '0;
      bs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      ch_q    <= ch_d;
      bs_q    <= bs_d;
    end
  end
endmodule

// File: tb/tb_text_console.sv
// tb_text_console: scoreboard bench for text_console with a registered-read RAM model
module tb_text_console;
  localparam int C = 40;
  localparam int R = 15;
  localparam int N = C * R;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_we;
  logic [9:0] cursor_addr;
  logic       busy;

  always #5 clk = ~clk;

  text_console dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .cursor_addr(cursor_addr), .busy(busy)
  );

  logic [7:0] ram [1024];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {int a; int d;} wr_t;
  wr_t        q[$];
  logic [7:0] exp_scr [N];
  int n_chk = 0, n_fail = 0;
  int cyc = 0, prev_wr = 0, last_wr = 0, bcnt = 0, last_busy = 0;
  int bcol = 0, brow = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy) bcnt <= bcnt + 1;
    else if (bcnt != 0) begin
      last_busy <= bcnt;
      bcnt <= 0;
    end
    if (mem_we) begin
      prev_wr <= last_wr;
      last_wr <= cyc;
      if (q.size() == 0) check("spurious_write", 1, 0);
      else begin
        check("wr_addr", mem_addr, q[0].a);
        check("wr_data", mem_wdata, q[0].d);
        q.delete(0);
      end
    end
  end

  task automatic push_wr(input int a, input int d);
    q.push_back('{a, d});
    exp_scr[a] = 8'(d);
  endtask

  task automatic push_clear();
    for (int i = 0; i < N; i++) push_wr(i, 8'h20);
  endtask

  task automatic push_scroll();
    for (int i = 0; i < N - C; i++) push_wr(i, exp_scr[i + C]);
    for (int i = N - C; i < N; i++) push_wr(i, 8'h20);
  endtask

  task automatic model(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7e) begin
      push_wr(brow * C + bcol, b);
      if (bcol < C - 1) bcol++;
      else begin
        bcol = 0;
        if (brow < R - 1) brow++;
        else push_scroll();
      end
    end else if (b == 8'h0d) bcol = 0;
    else if (b == 8'h0a) begin
      bcol = 0;
      if (brow < R - 1) brow++;
      else push_scroll();
    end else if (b == 8'h08) begin
      if (bcol > 0) begin
        bcol--;
        push_wr(brow * C + bcol, 8'h20);
      end
    end else if (b == 8'h0c) begin
      bcol = 0;
      brow = 0;
      push_clear();
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic send(input logic [7:0] b);
    model(b);
    wait_ready("send");
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_cur(input string tag, input int exp);
    wait_ready(tag);
    check(tag, cursor_addr, exp);
  endtask

  task automatic do_reset(input int ncyc);
    int n = 0;
    @(posedge clk);
    #1 reset = 1'b1;
    q.delete();
    bcol = 0;
    brow = 0;
    repeat (ncyc) begin
      @(negedge clk);
      check("rst_ready", in_ready, 0);
      check("rst_we", mem_we, 0);
      check("rst_busy", busy, 1);
      check("rst_cursor", cursor_addr, 0);
      check("rst_addr", mem_addr, 0);
    end
    push_clear();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check("clear_len", n, N);
  endtask

  initial begin
    int nbad;
    logic [7:0] e;
    do_reset(3);
    check_cur("reset_cursor", 0);

    send(8'h41);
    send(8'h42);
    check_cur("ab_cursor", 2);
    check("ab_spacing", last_wr - prev_wr, 2);

    send(8'h0d);
    for (int i = 0; i < C; i++) send(8'h61 + 8'(i % 26));
    check_cur("wrap_cursor", 40);
    send(8'h0d);
    check_cur("cr_cursor", 40);
    send(8'h0a);
    check_cur("lf_cursor", 80);
    send(8'h08);
    check_cur("bs_col0_cursor", 80);
    check("bs_col0_nowrite", q.size(), 0);

    send(8'h0c);
    check_cur("ff_cursor", 0);
    send(8'h58);
    send(8'h59);
    send(8'h08);
    check_cur("bs_cursor", 1);

    send(8'h0d);
    repeat (3) send(8'h0a);
    send(8'h61);
    send(8'h62);
    send(8'h63);
    check_cur("pre_ff_cursor", 123);
    send(8'h0c);
    check_cur("ff123_cursor", 0);

    for (int i = 0; i < N - 1; i++) send(8'h30 + 8'(i / C));
    send(8'h5a);
    check_cur("scroll_cursor", 560);
    @(negedge clk);
    check("scroll_busy", last_busy, 1160);
    for (int r = 0; r < R; r++) begin
      nbad = 0;
      for (int c = 0; c < C; c++) begin
        e = r < 13 ? 8'h30 + 8'(r + 1) : r == 13 ? (c == C - 1 ? 8'h5a : 8'h30 + 8'd14) : 8'h20;
        if (ram[r * C + c] !== e) nbad++;
      end
      check($sformatf("scroll_row%0d_bad", r), nbad, 0);
    end

    send(8'h0a);
    repeat (500) @(negedge clk);
    check("mid_scroll_busy", busy, 1);
    do_reset(1);
    check_cur("mid_reset_cursor", 0);
    nbad = 0;
    for (int i = 0; i < N; i++) if (ram[i] !== 8'h20) nbad++;
    check("mid_reset_blank", nbad, 0);
    repeat (4) @(negedge clk);
    check("queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
